// File: rtl/face_cmd_sequencer.sv
// Command FIFO and issue scheduler in front of FACE_TOP's instruction port.
// Each queued word is presented as a one-cycle pulse; long ops block issue until face_busy rises and falls.
module face_cmd_sequencer #(
  parameter int       DEPTH            = 8,
  parameter bit [6:0] SYS_OPCODE       = 7'b0001011,
  parameter bit [6:0] SHA_OPCODE       = 7'b0101011,
  parameter bit [2:0] SYS_CALC_FUNC    = 3'd1,
  parameter bit [2:0] SHA_ADDRSET_FUNC = 3'd0,
  parameter int       RISE_TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        flush,
  output logic [31:0] face_instr,
  input  logic        face_busy,
  output logic        seq_idle,
  output logic [15:0] issued_count,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(RISE_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RISE, S_WAIT_FALL} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [TW-1:0] timer, timer_next;
  logic [31:0]   instr_next;
  logic          empty, full, push, pop;
  logic          is_long, count_inc, err_set;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full && !flush && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign seq_idle  = (state == S_IDLE) && empty && !face_busy && !rst;

  // The word currently on face_instr is the one being classified in S_ISSUE.
  assign is_long = ((face_instr[6:0] == SYS_OPCODE) && (face_instr[9:7] == SYS_CALC_FUNC)) ||
                   ((face_instr[6:0] == SHA_OPCODE) && (face_instr[9:7] != SHA_ADDRSET_FUNC));

  // NOTE: storage array has no reset; the pointers alone define validity, so a reset
  // on the data would only add fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // Flush discards the queue; a same-cycle pop has already captured its word.
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    timer_next = timer;
    instr_next = '0;
    pop        = 1'b0;
    count_inc  = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !face_busy) begin
          pop        = 1'b1;
          instr_next = mem[rd_ptr[AW-1:0]];
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        count_inc = 1'b1;
        if (is_long) begin
          state_next = S_WAIT_RISE;
          timer_next = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT_RISE: begin
        if (face_busy) begin
          state_next = S_WAIT_FALL;
        end else begin
          timer_next = timer + 1'b1;
          if (timer_next == TW'(RISE_TIMEOUT)) begin
            err_set    = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_WAIT_FALL: begin
        if (!face_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      face_instr   <= '0;
      issued_count <= '0;
      err_timeout  <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      face_instr <= instr_next;
      if (count_inc) issued_count <= issued_count + 16'd1;
      if (err_set)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_face_cmd_sequencer.sv
// Directed self-checking bench for face_cmd_sequencer: issue pacing, busy blocking,
// FIFO full/order, rise timeout, flush and mid-operation reset.
module tb_face_cmd_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        flush;
  logic [31:0] face_instr;
  logic        face_busy;
  logic        seq_idle;
  logic [15:0] issued_count;
  logic        err_timeout;
  logic        err_clr;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] W_SHORT1  = 32'h0000_100B;
  localparam logic [31:0] W_SHORT2  = 32'h0000_200B;
  localparam logic [31:0] W_SHORT3  = 32'h0000_300B;
  localparam logic [31:0] W_CALC    = 32'h0000_008B;  // SYS opcode, func 1
  localparam logic [31:0] W_ADDRSET = 32'h0000_002B;  // SHA opcode, func 0
  localparam logic [31:0] W_SEEDSET = 32'h0000_00AB;  // SHA opcode, func 1
  localparam logic [31:0] W_NEXT    = 32'h0000_700B;
  localparam logic [31:0] W_LOST    = 32'h0000_900B;
  localparam logic [31:0] W_POST    = 32'h0000_C00B;

  face_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .flush        (flush),
    .face_instr   (face_instr),
    .face_busy    (face_busy),
    .seq_idle     (seq_idle),
    .issued_count (issued_count),
    .err_timeout  (err_timeout),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs change only here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_t1 [7];
  logic [31:0] got_q [$];

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    flush     = 1'b0;
    face_busy = 1'b0;
    err_clr   = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_seq_idle", seq_idle, 0);
    check("rst_face_instr", face_instr, 0);
    check("rst_issued_count", issued_count, 0);
    check("rst_err_timeout", err_timeout, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_seq_idle", seq_idle, 1);

    // 1: three short words, one pulse every two cycles with NOPs between
    exp_t1 = '{32'h0, W_SHORT1, 32'h0, W_SHORT2, 32'h0, W_SHORT3, 32'h0};
    cmd_valid = 1'b1;
    cmd_data  = W_SHORT1;
    tick(); check("t1_e1", face_instr, exp_t1[0]);
    cmd_data = W_SHORT2;
    tick(); check("t1_e2", face_instr, exp_t1[1]);
    cmd_data = W_SHORT3;
    tick(); check("t1_e3", face_instr, exp_t1[2]);
    cmd_valid = 1'b0;
    for (int i = 3; i < 7; i++) begin
      tick();
      check($sformatf("t1_e%0d", i + 1), face_instr, exp_t1[i]);
    end
    check("t1_count", issued_count, 3);

    // 2: calc blocks the following addrset until busy has risen and fallen
    cmd_valid = 1'b1;
    cmd_data  = W_CALC;
    tick(); check("t2_push_calc", face_instr, 0);
    cmd_data = W_ADDRSET;
    tick(); check("t2_issue_calc", face_instr, W_CALC);
    cmd_valid = 1'b0;
    tick(); check("t2_nop_after_calc", face_instr, 0);
    face_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("t2_busy_%0d", i), face_instr, 0);
    end
    face_busy = 1'b0;
    tick(); check("t2_fall_nop", face_instr, 0);
    tick(); check("t2_issue_addrset", face_instr, W_ADDRSET);
    tick(); check("t2_count", issued_count, 5);
    check("t2_nop_end", face_instr, 0);

    // 3: fill beyond DEPTH while busy, then drain in order
    face_busy = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cmd_data = 32'h0001_0000 * (i + 1);
      #1;
      check($sformatf("t3_ready_%0d", i), cmd_ready, (i < DEPTH) ? 1 : 0);
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_seq_idle_busy", seq_idle, 0);
    check("t3_held", face_instr, 0);
    face_busy = 1'b0;
    got_q.delete();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (face_instr != 0) got_q.push_back(face_instr);
    end
    check("t3_issued_n", got_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < got_q.size()) check($sformatf("t3_order_%0d", i), got_q[i], 32'h0001_0000 * (i + 1));
    end
    check("t3_count", issued_count, 5 + DEPTH);

    // 4: seedset with busy held low times out after 16 wait cycles
    cmd_valid = 1'b1;
    cmd_data  = W_SEEDSET;
    tick(); check("t4_push", face_instr, 0);
    cmd_data = W_NEXT;
    tick(); check("t4_issue_seedset", face_instr, W_SEEDSET);
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("t4_wait_err_%0d", i), err_timeout, 0);
    end
    tick();
    check("t4_err_set", err_timeout, 1);
    check("t4_err_nop", face_instr, 0);
    tick(); check("t4_next_issue", face_instr, W_NEXT);
    tick(); check("t4_err_held", err_timeout, 1);
    check("t4_count", issued_count, 15);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_cleared", err_timeout, 0);

    // 5: flush with simultaneous push empties the queue and drops the push
    face_busy = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 32'h0002_0000 * (i + 1);
      tick();
    end
    cmd_data = 32'h00AA_0000;
    flush    = 1'b1;
    #1;
    check("t5_ready_flush", cmd_ready, 0);
    tick();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    check("t5_idle_busy", seq_idle, 0);
    face_busy = 1'b0;
    #1;
    check("t5_seq_idle", seq_idle, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5_no_issue_%0d", i), face_instr, 0);
    end
    check("t5_count", issued_count, 15);

    // 6: reset during S_WAIT_FALL, then no issue until busy drops
    cmd_valid = 1'b1;
    cmd_data  = W_CALC;
    tick();
    cmd_valid = 1'b0;
    tick(); check("t6_issue_calc", face_instr, W_CALC);
    tick();
    face_busy = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = W_LOST;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_instr", face_instr, 0);
    check("t6_rst_count", issued_count, 0);
    check("t6_rst_ready", cmd_ready, 0);
    check("t6_rst_idle", seq_idle, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t6_ready_after", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = W_POST;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_blocked_%0d", i), face_instr, 0);
    end
    face_busy = 1'b0;
    tick(); check("t6_issue_post", face_instr, W_POST);
    tick(); check("t6_count", issued_count, 1);
    tick(); check("t6_lost_gone_a", face_instr, 0);
    tick(); check("t6_lost_gone_b", face_instr, 0);
    check("t6_seq_idle", seq_idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
